shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 116 +++++++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: accepts an operation, shifts up to STEP_MAX bits
// per clock, then pulses done for one cycle with the result held afterwards.
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// SHIFT | working register shifting, remaining counts down
// DONE  | one-cycle completion; start here is accepted back-to-back
module shift_sequencer #(
    parameter int STEP_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    if (STEP_MAX != 1 && STEP_MAX != 2) begin : g_bad_step_max
        $error("shift_sequencer: STEP_MAX must be 1 or 2");
    end

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] STEP_LIM = 2'(STEP_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state, state_next;
    logic [31:0] work, work_next;
    logic [1:0]  op_q, op_next;
    logic [4:0]  remaining, remaining_next;
    logic [1:0]  step;

    // One shift step of 1 or 2 bits; amt=0 leaves the value unchanged.
    function automatic logic [31:0] shift_step(input logic [1:0] kind,
                                               input logic [31:0] w,
                                               input logic [1:0] amt);
        logic [31:0] r;
        r = w;
        case (kind)
            OP_SLL:  r = w << amt;
            OP_SRL:  r = w >> amt;
            OP_SRA:  r = $signed(w) >>> amt;
            OP_ROTR: begin
                case (amt)
                    2'd1:    r = {w[0], w[31:1]};
                    2'd2:    r = {w[1:0], w[31:2]};
                    default: r = w;
                endcase
            end
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= 32'd0;
            op_q      <= OP_SLL;
            remaining <= 5'd0;
        end else begin
            state     <= state_next;
            work      <= work_next;
            op_q      <= op_next;
            remaining <= remaining_next;
        end
    end

    // step = min(remaining, STEP_MAX); only used while remaining is nonzero
    assign step = (remaining < {3'b000, STEP_LIM}) ? remaining[1:0] : STEP_LIM;

    always_comb begin
        state_next     = state;
        work_next      = work;
        op_next        = op_q;
        remaining_next = remaining;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    work_next      = data_in;
                    op_next        = op;
                    remaining_next = shamt;
                    state_next     = SHIFT;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (remaining != 5'd0) begin
                    work_next      = shift_step(op_q, work, step);
                    remaining_next = remaining - {3'b000, step};
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign result = work;
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (STEP_MAX=2 and STEP_MAX=1) driven in
// parallel, checked every cycle against an edge-count model plus literal results.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] ores [2];
    logic        obusy [2];
    logic        odone [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
        .data_in(data_in), .result(ores[0]), .busy(obusy[0]), .done(odone[0])
    );

    shift_sequencer #(.STEP_MAX(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
        .data_in(data_in), .result(ores[1]), .busy(obusy[1]), .done(odone[1])
    );

    // Model: edges since the accept edge, plus the latched operation.
    int          mk [2];
    logic        mact [2];
    logic [1:0]  mop [2];
    logic [4:0]  ms [2];
    logic [31:0] md [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0; mact[i] = 1'b0; mop[i] = 2'b00; ms[i] = 5'd0; md[i] = 32'd0;
        end
    end

    function automatic int stp(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int nsteps(input int i);
        return (int'(ms[i]) + stp(i) - 1) / stp(i);
    endfunction

    function automatic logic [31:0] full_shift(input logic [1:0] k,
                                               input logic [31:0] d, input int amt);
        logic [31:0] r;
        case (k)
            2'b00: r = d << amt;
            2'b01: r = d >> amt;
            2'b10: r = $signed(d) >>> amt;
            default: r = (amt == 0) ? d : ((d >> amt) | (d << (32 - amt)));
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mact[i] = 1'b0; mk[i] = 0; md[i] = 32'd0; ms[i] = 5'd0; mop[i] = 2'b00;
            end else if (start && (!mact[i] || mk[i] == nsteps(i) + 1)) begin
                mact[i] = 1'b1; mk[i] = 0; md[i] = data_in; ms[i] = shamt; mop[i] = op;
            end else if (mact[i]) begin
                mk[i] = mk[i] + 1;
                if (mk[i] > nsteps(i) + 1) mact[i] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare both instances to the model.
    task automatic tick();
        int amt;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            amt = mk[i] * stp(i);
            if (amt > int'(ms[i])) amt = int'(ms[i]);
            check($sformatf("cyc_res_i%0d", i), ores[i], full_shift(mop[i], md[i], amt));
            check($sformatf("cyc_busy_i%0d", i), {31'd0, obusy[i]},
                  {31'd0, mact[i] && mk[i] <= nsteps(i)});
            check($sformatf("cyc_done_i%0d", i), {31'd0, odone[i]},
                  {31'd0, mact[i] && mk[i] == nsteps(i) + 1});
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] s,
                          input logic [31:0] d, input logic [31:0] exp_res,
                          input int exp_l2, input int exp_l1, input int reassert_at);
        int l2, l1;
        reset = 1'b0; start = 1'b1; op = o; shamt = s; data_in = d;
        l2 = -1; l1 = -1;
        for (int e = 0; e < 40 && (l2 < 0 || l1 < 0); e++) begin
            tick();
            if (e == 0) begin
                start = 1'b0; op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
            end
            if (e == reassert_at) begin
                start = 1'b1; op = 2'b10; shamt = 5'd3; data_in = 32'hFFFF_FFFF;
            end else if (e == reassert_at + 1) begin
                start = 1'b0;
            end
            if (odone[0] && l2 < 0) begin
                l2 = e;
                check({name, "_res_s2"}, ores[0], exp_res);
            end
            if (odone[1] && l1 < 0) begin
                l1 = e;
                check({name, "_res_s1"}, ores[1], exp_res);
            end
        end
        start = 1'b0;
        check({name, "_lat_s2"}, 32'(l2), 32'(exp_l2));
        check({name, "_lat_s1"}, 32'(l1), 32'(exp_l1));
    endtask

    initial begin
        int l2, seen;
        reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'd0;
        repeat (3) tick();
        check("rst_res", ores[0], 32'd0);
        check("rst_busy", {31'd0, obusy[0]}, 32'd0);
        check("rst_done", {31'd0, odone[0]}, 32'd0);

        // start on the first edge after reset is released
        run_op("sll2", 2'b00, 5'd2, 32'h0000_0002, 32'h0000_0008, 2, 3, -1);
        tick();
        run_op("sra4", 2'b10, 5'd4, 32'hF0F0_F0F0, 32'hFF0F_0F0F, 3, 5, -1);
        run_op("srl4", 2'b01, 5'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3, 5, -1);
        run_op("srl31", 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 17, 32, -1);
        run_op("ignore", 2'b00, 5'd10, 32'h0000_0001, 32'h0000_0400, 6, 11, 2);

        // back-to-back: start held in DONE
        start = 1'b1; op = 2'b11; shamt = 5'd8; data_in = 32'h1234_1234;
        l2 = -1;
        for (int e = 0; e < 20 && l2 < 0; e++) begin
            tick();
            if (e == 0) start = 1'b0;
            if (odone[0]) begin
                l2 = e;
                check("rotr8_res", ores[0], 32'h3412_3412);
                start = 1'b1; op = 2'b00; shamt = 5'd0; data_in = 32'h0000_0010;
            end
        end
        check("rotr8_lat", 32'(l2), 32'd5);
        tick();
        start = 1'b0;
        check("b2b_busy", {31'd0, obusy[0]}, 32'd1);
        check("b2b_res_acc", ores[0], 32'h0000_0010);
        tick();
        check("b2b_done", {31'd0, odone[0]}, 32'd1);
        check("b2b_res", ores[0], 32'h0000_0010);
        repeat (12) tick();

        // reset on edge 2 of a long operation
        start = 1'b1; op = 2'b00; shamt = 5'd20; data_in = 32'h0000_ABCD;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_res", ores[0], 32'd0);
        check("abort_busy", {31'd0, obusy[0]}, 32'd0);
        check("abort_done", {31'd0, odone[0]}, 32'd0);
        check("abort_res_s1", ores[1], 32'd0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (odone[0] || odone[1]) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        run_op("sra5", 2'b10, 5'd5, 32'h8000_0000, 32'hFC00_0000, 4, 6, -1);
        run_op("sll0", 2'b00, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, -1);
        run_op("rotr31", 2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002, 17, 32, -1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
